// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the raster timing sequencer.
package video_timing_pkg;

    // Phases of one horizontal or vertical sequencer, in raster order.
    typedef enum logic [1:0] {
        PH_SYNC = 2'd0,
        PH_BP   = 2'd1,
        PH_ACT  = 2'd2,
        PH_FP   = 2'd3
    } phase_t;

    // Phase that follows ph; FP wraps back to SYNC.
    function automatic phase_t next_phase(phase_t ph);
        phase_t nxt;
        nxt = PH_SYNC;
        unique case (ph)
            PH_SYNC: nxt = PH_BP;
            PH_BP:   nxt = PH_ACT;
            PH_ACT:  nxt = PH_FP;
            PH_FP:   nxt = PH_SYNC;
        endcase
        return nxt;
    endfunction

    // Total enabled cycles in one line (or total lines in one frame).
    function automatic int unsigned seq_total(int unsigned len_sync, int unsigned len_bp,
                                              int unsigned len_act, int unsigned len_fp);
        return len_sync + len_bp + len_act + len_fp;
    endfunction

    // Default geometry: 28-cycle lines, 14-line frames, 392-cycle frames.
    localparam int unsigned DEF_LINE_LEN  = seq_total(4, 4, 16, 4);
    localparam int unsigned DEF_FRAME_LINES = seq_total(2, 2, 8, 2);
    localparam int unsigned DEF_FRAME_LEN = DEF_LINE_LEN * DEF_FRAME_LINES;

endpackage

// File: rtl/timing_phase_counter.sv
// One phase sequencer: walks SYNC -> BP -> ACT -> FP with a count inside each phase.
module timing_phase_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned LEN_SYNC = 4,
    parameter int unsigned LEN_BP   = 4,
    parameter int unsigned LEN_ACT  = 16,
    parameter int unsigned LEN_FP   = 4,
    parameter int unsigned CW       = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          advance_i,
    output phase_t        phase_o,
    output logic [CW-1:0] count_o,
    output logic          last_o
);

    localparam logic [CW-1:0] SyncLast = CW'(LEN_SYNC - 1);
    localparam logic [CW-1:0] BpLast   = CW'(LEN_BP - 1);
    localparam logic [CW-1:0] ActLast  = CW'(LEN_ACT - 1);
    localparam logic [CW-1:0] FpLast   = CW'(LEN_FP - 1);

    phase_t        phase_q, phase_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] phase_last;

    // Final count value of the phase currently being sequenced.
    always_comb begin
        phase_last = SyncLast;
        unique case (phase_q)
            PH_SYNC: phase_last = SyncLast;
            PH_BP:   phase_last = BpLast;
            PH_ACT:  phase_last = ActLast;
            PH_FP:   phase_last = FpLast;
        endcase
    end

    // Count up within the phase; on its final count, restart at 0 in the next phase.
    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        if (advance_i) begin
            if (count_q == phase_last) begin
                count_d = '0;
                phase_d = next_phase(phase_q);
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // State register; reset parks the sequencer at the start of SYNC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PH_SYNC;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
        end
    end

    assign phase_o = phase_q;
    assign count_o = count_q;
    assign last_o  = (phase_q == PH_FP) && (count_q == FpLast);

endmodule

// File: rtl/video_timing_sequencer.sv
// Raster timing controller: chains a horizontal and a vertical phase sequencer and
// decodes sync, blank, strobes and active-pixel coordinates from their state.
module video_timing_sequencer
    import video_timing_pkg::*;
#(
    parameter int unsigned H_SYNC = 4,
    parameter int unsigned H_BP   = 4,
    parameter int unsigned H_ACT  = 16,
    parameter int unsigned H_FP   = 4,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 2,
    parameter int unsigned V_ACT  = 8,
    parameter int unsigned V_FP   = 2,
    parameter int unsigned CW     = 10
) (
    input  logic          CK,
    input  logic          RSTN,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          csync,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y
);

    phase_t        h_phase, v_phase;
    logic [CW-1:0] h_count, v_count;
    logic          h_last, v_last;
    logic          v_advance;

    // The vertical sequencer steps once per line, on the enabled cycle that ends it.
    assign v_advance = en & h_last;

    timing_phase_counter #(
        .LEN_SYNC (H_SYNC),
        .LEN_BP   (H_BP),
        .LEN_ACT  (H_ACT),
        .LEN_FP   (H_FP),
        .CW       (CW)
    ) u_h_seq (
        .clk_i     (CK),
        .rst_ni    (RSTN),
        .advance_i (en),
        .phase_o   (h_phase),
        .count_o   (h_count),
        .last_o    (h_last)
    );

    timing_phase_counter #(
        .LEN_SYNC (V_SYNC),
        .LEN_BP   (V_BP),
        .LEN_ACT  (V_ACT),
        .LEN_FP   (V_FP),
        .CW       (CW)
    ) u_v_seq (
        .clk_i     (CK),
        .rst_ni    (RSTN),
        .advance_i (v_advance),
        .phase_o   (v_phase),
        .count_o   (v_count),
        .last_o    (v_last)
    );

    // Moore decode of both sequencers; only the strobes look at en.
    always_comb begin
        logic h_act, v_act, h_origin;
        h_act       = (h_phase == PH_ACT);
        v_act       = (v_phase == PH_ACT);
        h_origin    = (h_phase == PH_SYNC) && (h_count == '0);
        hsync       = (h_phase == PH_SYNC);
        vsync       = (v_phase == PH_SYNC);
        csync       = hsync ^ vsync;
        blank       = !(h_act && v_act);
        line_start  = en && h_origin;
        frame_start = en && h_origin && (v_phase == PH_SYNC) && (v_count == '0);
        pos_x       = (h_act && v_act) ? h_count : '0;
        pos_y       = v_act ? v_count : '0;
    end

    // The final enabled cycle of a frame wraps both sequencers to the frame origin together.
    frame_wrap_a: assert property (@(posedge CK) disable iff (!RSTN)
        (en && h_last && v_last) |=>
        (h_phase == PH_SYNC && h_count == '0 && v_phase == PH_SYNC && v_count == '0));

endmodule

// File: tb/tb_video_timing_sequencer.sv
// Self-checking bench: random pixel-enable stimulus against a raster-position model.
module tb_video_timing_sequencer;

    logic CK;
    logic RSTN;
    logic en;

    logic       hs_a, vs_a, cs_a, bl_a, ls_a, fs_a;
    logic [9:0] px_a, py_a;
    logic       hs_b, vs_b, cs_b, bl_b, ls_b, fs_b;
    logic [9:0] px_b, py_b;

    int unsigned k;
    int          checks;
    int          errors;
    logic        chk_fixed;
    int          blank_lo;
    int          fs_hits;

    video_timing_sequencer u_dut_a (
        .CK          (CK),
        .RSTN        (RSTN),
        .en          (en),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .csync       (cs_a),
        .blank       (bl_a),
        .line_start  (ls_a),
        .frame_start (fs_a),
        .pos_x       (px_a),
        .pos_y       (py_a)
    );

    video_timing_sequencer #(
        .H_SYNC (1), .H_BP (1), .H_ACT (1), .H_FP (1),
        .V_SYNC (1), .V_BP (1), .V_ACT (1), .V_FP (1),
        .CW     (10)
    ) u_dut_b (
        .CK          (CK),
        .RSTN        (RSTN),
        .en          (en),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .csync       (cs_b),
        .blank       (bl_b),
        .line_start  (ls_b),
        .frame_start (fs_b),
        .pos_x       (px_b),
        .pos_y       (py_b)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (enabled cycle %0d)", tag, obs, exp, k);
        end
    endtask

    // Expected outputs after k enabled cycles, from the raster position alone.
    function automatic logic [31:0] model(input int unsigned kk,
                                          input int unsigned hs, input int unsigned hb,
                                          input int unsigned ha, input int unsigned hf,
                                          input int unsigned vs, input int unsigned vb,
                                          input int unsigned va, input int unsigned vf,
                                          input logic en_v);
        int unsigned ll, fl, f, l, h;
        logic hsy, vsy, hact, vact;
        logic [9:0] px, py;
        ll   = hs + hb + ha + hf;
        fl   = ll * (vs + vb + va + vf);
        f    = kk % fl;
        l    = f / ll;
        h    = f % ll;
        hsy  = (h < hs);
        vsy  = (l < vs);
        hact = (h >= hs + hb) && (h < hs + hb + ha);
        vact = (l >= vs + vb) && (l < vs + vb + va);
        px   = (hact && vact) ? 10'(h - hs - hb) : 10'd0;
        py   = vact ? 10'(l - vs - vb) : 10'd0;
        return {6'b0, hsy, vsy, hsy ^ vsy, !(hact && vact), en_v && (h == 0), en_v && (f == 0),
                px, py};
    endfunction

    function automatic logic [31:0] obs_a();
        return {6'b0, hs_a, vs_a, cs_a, bl_a, ls_a, fs_a, px_a, py_a};
    endfunction

    function automatic logic [31:0] obs_b();
        return {6'b0, hs_b, vs_b, cs_b, bl_b, ls_b, fs_b, px_b, py_b};
    endfunction

    // hsync=1 vsync=1 csync=0 blank=1, no strobes, coordinates zero.
    function automatic logic [31:0] reset_exp();
        return {6'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
    endfunction

    // One clock: drive en, compare both DUTs against the model, then count the edge.
    task automatic step(input logic en_v);
        @(negedge CK);
        en = en_v;
        #1;
        check_eq("seq_default", obs_a(), model(k, 4, 4, 16, 4, 2, 2, 8, 2, en));
        check_eq("seq_len1", obs_b(), model(k, 1, 1, 1, 1, 1, 1, 1, 1, en));
        if (chk_fixed && en) begin
            if (k < 392 && !bl_a) blank_lo++;
            if (k <= 392 && fs_a) fs_hits++;
            if (k == 120) check_eq("first_active", {11'd0, bl_a, px_a, py_a}, 32'd0);
            if (k == 331) check_eq("last_active", {11'd0, bl_a, px_a, py_a},
                                   {11'd0, 1'b0, 10'd15, 10'd7});
            if (k == 332) check_eq("after_active", {31'd0, bl_a}, 32'd1);
        end
        if (en) k++;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        k         = 0;
        chk_fixed = 1'b0;
        blank_lo  = 0;
        fs_hits   = 0;
        RSTN      = 1'b0;
        en        = 1'b0;
        repeat (3) @(negedge CK);
        #1;
        check_eq("reset_default", obs_a(), reset_exp());
        check_eq("reset_len1", obs_b(), reset_exp());
        @(negedge CK);
        RSTN = 1'b1;

        // Continuous enable across two frames.
        chk_fixed = 1'b1;
        for (int c = 0; c < 800; c++) step(1'b1);
        chk_fixed = 1'b0;
        check_eq("blank_low_count", 32'(blank_lo), 32'd128);
        check_eq("frame_start_count", 32'(fs_hits), 32'd2);

        // Enable toggled at random.
        for (int c = 0; c < 1500; c++) step(1'(($urandom() >> 7) & 1));

        // Run to a mid-frame point, then reset between clock edges.
        for (int c = 0; c < 400 && (k % 392) != 200; c++) step(1'b1);
        check_eq("reached_mid_frame", 32'(k % 392), 32'd200);
        @(posedge CK);
        #2;
        RSTN = 1'b0;
        en   = 1'b0;
        #1;
        check_eq("async_reset_default", obs_a(), reset_exp());
        check_eq("async_reset_len1", obs_b(), reset_exp());
        @(negedge CK);
        RSTN = 1'b1;
        k    = 0;
        step(1'b1);
        check_eq("frame_start_after_reset", {30'd0, fs_a, fs_b}, 32'd3);
        for (int c = 0; c < 420; c++) step(1'b1);
        for (int c = 0; c < 300; c++) step(1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
